warp_sched_ctrl: RTL and testbench
==================================

Name: warp_sched_ctrl

Overview:
- Per-SM warp scheduler that sequences the round-robin fetch unit.
- Tracks per-warp slot state (active, pending, stalled, at barrier) and builds each round's eligible warp mask.
- Offers the mask to the fetch unit over a valid/ready handshake, consumes the per-warp fetch beats until the last beat, then starts the next round.
- Handles barrier release and warp exit, and reports kernel completion.

Parameters:
- NUM_WARPS, 32, number of warp slots; must equal the fetch unit's mask width.
- WID_W, 5, slot index width, $clog2(NUM_WARPS).
- ROUND_TIMEOUT, 1024, maximum cycles in ROUND without a beat before err[3] is flagged.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; latches launch_mask and begins scheduling
- launch_mask  in  NUM_WARPS  slots that hold a launched warp
- fetch_s_tvalid  out  1  mask offer valid, to the fetch unit's s_tvalid
- fetch_s_tready  in  1  from the fetch unit's s_tready
- fetch_warp_mask  out  NUM_WARPS  eligible slots for this round
- fetch_beat_valid  in  1  fetch unit per-warp beat (m_tvalid_update_queue)
- fetch_beat_last  in  1  last beat of the round
- fetch_beat_id  in  WID_W  slot fetched on this beat
- issue_done_valid, issue_done_id  in  1, WID_W  decode/issue consumed that slot's instruction; clears pending
- stall_set_valid, stall_set_id  in  1, WID_W  long-latency op issued; mark slot stalled
- stall_clr_valid, stall_clr_id  in  1, WID_W  writeback done; clear stalled
- bar_valid, bar_id  in  1, WID_W  slot reached a barrier
- exit_valid, exit_id  in  1, WID_W  slot executed exit
- busy  out  1  state != IDLE
- all_done  out  1  one-cycle pulse when the last active warp exits
- err  out  4  one-cycle sticky-free error pulses; meanings under Error bits

Behaviour:
- Reset (asynchronous, rst_n low):
  - All slot bits cleared; state = IDLE.
  - fetch_s_tvalid = 0, fetch_warp_mask = 0, busy = 0, all_done = 0, err = 0.
  - Reset during any state aborts the round immediately; no beats are consumed afterward.
- Per-slot bits: active, pending, stalled, barrier.
  - ready = active & ~pending & ~stalled & ~barrier.
- State machine:
  - IDLE:
    - start moves to COLLECT and sets active = launch_mask.
    - start with launch_mask == 0: stay IDLE and pulse all_done next cycle.
    - start outside IDLE is ignored.
  - COLLECT:
    - If ready != 0: register fetch_warp_mask = ready, go to OFFER.
    - Else if active == 0: go to IDLE and pulse all_done.
    - Else remain in COLLECT.
  - OFFER:
    - fetch_s_tvalid = 1; fetch_warp_mask held stable.
    - On fetch_s_tvalid & fetch_s_tready: drop fetch_s_tvalid next cycle, go to ROUND, load the outstanding mask from the offered mask.
  - ROUND, on each fetch_beat_valid:
    - Set pending[id] and clear outstanding[id].
    - If id was not outstanding, pulse err[0].
    - On fetch_beat_last: go to COLLECT.
    - If outstanding is still nonzero after the last beat, or becomes zero without last, pulse err[2] and go to COLLECT anyway.
    - A timeout counter resets on every beat; reaching ROUND_TIMEOUT pulses err[3] and returns to COLLECT.
- Latency:
  - Minimum 2 cycles from ready to fetch_s_tvalid (COLLECT register stage, then OFFER).
  - Back-to-back rounds: COLLECT is entered the cycle after the last beat.
- Event priority for the same slot in the same cycle:
  - exit overrides everything: clears active, pending, stalled and barrier.
  - stall_set wins over stall_clr.
  - A fetch beat setting pending wins over issue_done clearing it.
- Events may arrive in any state; they update the slot bits immediately.
- Barrier:
  - bar_valid sets barrier[id].
  - When (barrier & active) == active and active != 0, all barrier bits clear on the next cycle.
  - An exiting warp is removed from the barrier set, so it can release waiting warps.
- Error bits:
  - err[0]: beat for a slot not outstanding.
  - err[1]: exit, stall_set or bar event on an inactive slot; the event is ignored.
  - err[2]: last-beat mismatch.
  - err[3]: round timeout.
- Arithmetic: the timeout counter is $clog2(ROUND_TIMEOUT)+1 bits and saturates.

Decomposition:
- Shared package gets:
  - state enum typedef sched_state_e with values IDLE, COLLECT, OFFER, ROUND;
  - err bit index constants KIANA_SCHED_ERR_*, alongside the existing fetcher error defines;
  - NUM_WARPS/WID_W defaults.
- One sub-module, warp_slot_table: holds the per-slot bits, applies the event priority and barrier release, and outputs the ready and active vectors. The FSM stays in warp_sched_ctrl.

Test Plan:
- Single round:
  - Stimulus: start, launch_mask=32'h0000_0005; fetch unit accepts after 3 cycles and emits beats id 0, then id 2 with last.
  - Required: fetch_warp_mask=32'h5 held through OFFER; pending=32'h5; no err.
  - Then issue_done for ids 0 and 2: the next offer has mask 32'h5.
- Stall exclusion: launch 32'h0F, stall_set id 1 before the first COLLECT; first offer is 32'h0D. After stall_clr id 1 and all issue_done, the next offer is 32'h0F.
- Barrier: launch 32'h3, bar ids 0 and 1 on separate cycles. COLLECT stalls with no offer until the second arrival; the barrier clears the next cycle and the offer is 32'h3.
- Exit and done: launch 32'h1, one round, then exit id 0. all_done pulses once, busy falls, and the state is IDLE.
- Protocol errors:
  - A beat for id 4 with mask 32'h1 gives an err[0] pulse.
  - A last beat with id 1 still outstanding gives err[2], and the FSM returns to COLLECT.
  - No beats for ROUND_TIMEOUT cycles gives err[3].
- Reset mid-round: deassert rst_n during ROUND. All outputs go to zero immediately; after release, start with 32'h2 offers 32'h2.

Source files
------------

// File: rtl/warp_sched_ctrl_pkg.sv
// Shared types and constants for the per-SM warp scheduler and its slot table.
package warp_sched_ctrl_pkg;

    localparam int DEF_NUM_WARPS = 32;
    localparam int DEF_WID_W     = $clog2(DEF_NUM_WARPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OFFER   = 2'd2,
        ROUND   = 2'd3
    } sched_state_e;

    // Bit positions within the scheduler err pulse vector.
    localparam int KIANA_SCHED_ERR_BAD_BEAT      = 0;
    localparam int KIANA_SCHED_ERR_INACTIVE_EVT  = 1;
    localparam int KIANA_SCHED_ERR_LAST_MISMATCH = 2;
    localparam int KIANA_SCHED_ERR_TIMEOUT       = 3;

endpackage

// File: rtl/warp_slot_table.sv
// Per-warp slot bits (active, pending, stalled, barrier) with event priority and
// barrier release; produces the ready and active vectors for the scheduler FSM.
module warp_slot_table
    import warp_sched_ctrl_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int WID_W     = DEF_WID_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [NUM_WARPS-1:0] load_mask_i,
    input  logic                 beat_valid_i,
    input  logic [WID_W-1:0]     beat_id_i,
    input  logic                 issue_done_valid_i,
    input  logic [WID_W-1:0]     issue_done_id_i,
    input  logic                 stall_set_valid_i,
    input  logic [WID_W-1:0]     stall_set_id_i,
    input  logic                 stall_clr_valid_i,
    input  logic [WID_W-1:0]     stall_clr_id_i,
    input  logic                 bar_valid_i,
    input  logic [WID_W-1:0]     bar_id_i,
    input  logic                 exit_valid_i,
    input  logic [WID_W-1:0]     exit_id_i,
    output logic [NUM_WARPS-1:0] ready_o,
    output logic [NUM_WARPS-1:0] active_o,
    output logic                 inactive_err_o
);

    logic [NUM_WARPS-1:0] active_q, active_d;
    logic [NUM_WARPS-1:0] pending_q, pending_d;
    logic [NUM_WARPS-1:0] stalled_q, stalled_d;
    logic [NUM_WARPS-1:0] barrier_q, barrier_d;
    logic [NUM_WARPS-1:0] active_base;
    logic                 bar_release;

    // A launch in the same cycle makes its slots eligible for that cycle's events.
    assign active_base = load_i ? load_mask_i : active_q;
    assign bar_release = ((barrier_q & active_q) == active_q) && (active_q != '0);

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        active_d  = active_base;
        pending_d = load_i ? '0 : pending_q;
        stalled_d = load_i ? '0 : stalled_q;
        barrier_d = (load_i || bar_release) ? '0 : barrier_q;

        // Later assignments win: issue_done < beat, stall_clr < stall_set, exit last.
        if (issue_done_valid_i)                        pending_d[issue_done_id_i] = 1'b0;
        if (beat_valid_i && active_base[beat_id_i])    pending_d[beat_id_i]       = 1'b1;
        if (stall_clr_valid_i)                         stalled_d[stall_clr_id_i]  = 1'b0;
        if (stall_set_valid_i && active_base[stall_set_id_i]) stalled_d[stall_set_id_i] = 1'b1;
        if (bar_valid_i && active_base[bar_id_i])      barrier_d[bar_id_i]        = 1'b1;
        if (exit_valid_i && active_base[exit_id_i]) begin
            active_d[exit_id_i]  = 1'b0;
            pending_d[exit_id_i] = 1'b0;
            stalled_d[exit_id_i] = 1'b0;
            barrier_d[exit_id_i] = 1'b0;
        end

        inactive_err_o = (exit_valid_i      && !active_base[exit_id_i])
                      || (stall_set_valid_i && !active_base[stall_set_id_i])
                      || (bar_valid_i       && !active_base[bar_id_i]);
    end

    // NOTE: the slot vectors are plain flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            pending_q <= '0;
            stalled_q <= '0;
            barrier_q <= '0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            stalled_q <= stalled_d;
            barrier_q <= barrier_d;
        end
    end

    assign ready_o  = active_q & ~pending_q & ~stalled_q & ~barrier_q;
    assign active_o = active_q;

endmodule

// File: rtl/warp_sched_ctrl.sv
// Per-SM warp scheduler: builds each round's eligible mask, offers it to the
// round-robin fetch unit, tracks the returned beats and reports completion/errors.
module warp_sched_ctrl
    import warp_sched_ctrl_pkg::*;
#(
    parameter int NUM_WARPS     = DEF_NUM_WARPS,
    parameter int WID_W         = $clog2(NUM_WARPS),
    parameter int ROUND_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_WARPS-1:0] launch_mask,
    output logic                 fetch_s_tvalid,
    input  logic                 fetch_s_tready,
    output logic [NUM_WARPS-1:0] fetch_warp_mask,
    input  logic                 fetch_beat_valid,
    input  logic                 fetch_beat_last,
    input  logic [WID_W-1:0]     fetch_beat_id,
    input  logic                 issue_done_valid,
    input  logic [WID_W-1:0]     issue_done_id,
    input  logic                 stall_set_valid,
    input  logic [WID_W-1:0]     stall_set_id,
    input  logic                 stall_clr_valid,
    input  logic [WID_W-1:0]     stall_clr_id,
    input  logic                 bar_valid,
    input  logic [WID_W-1:0]     bar_id,
    input  logic                 exit_valid,
    input  logic [WID_W-1:0]     exit_id,
    output logic                 busy,
    output logic                 all_done,
    output logic [3:0]           err
);

    localparam int CNT_W = $clog2(ROUND_TIMEOUT) + 1;

    sched_state_e         state_q, state_d;
    logic [NUM_WARPS-1:0] mask_q, mask_d;
    logic [NUM_WARPS-1:0] outst_q, outst_d;
    logic [CNT_W-1:0]     tmo_q, tmo_d;
    logic                 tvalid_q, tvalid_d;
    logic                 all_done_q, all_done_d;
    logic [3:0]           err_q, err_d;

    logic [NUM_WARPS-1:0] ready, active;
    logic                 inactive_err;
    logic                 launch;
    logic                 beat;

    assign launch = start && (state_q == IDLE);
    assign beat   = fetch_beat_valid && (state_q == ROUND);

    warp_slot_table #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_slot (
        .clk                (clk),
        .rst_n              (rst_n),
        .load_i             (launch),
        .load_mask_i        (launch_mask),
        .beat_valid_i       (beat),
        .beat_id_i          (fetch_beat_id),
        .issue_done_valid_i (issue_done_valid),
        .issue_done_id_i    (issue_done_id),
        .stall_set_valid_i  (stall_set_valid),
        .stall_set_id_i     (stall_set_id),
        .stall_clr_valid_i  (stall_clr_valid),
        .stall_clr_id_i     (stall_clr_id),
        .bar_valid_i        (bar_valid),
        .bar_id_i           (bar_id),
        .exit_valid_i       (exit_valid),
        .exit_id_i          (exit_id),
        .ready_o            (ready),
        .active_o           (active),
        .inactive_err_o     (inactive_err)
    );

    always_comb begin
        logic [NUM_WARPS-1:0] outst_left;
        state_d    = state_q;
        mask_d     = mask_q;
        outst_d    = outst_q;
        tmo_d      = tmo_q;
        tvalid_d   = tvalid_q;
        all_done_d = 1'b0;
        err_d      = '0;
        err_d[KIANA_SCHED_ERR_INACTIVE_EVT] = inactive_err;
        outst_left = outst_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (launch_mask != '0) state_d = COLLECT;
                    else                   all_done_d = 1'b1;
                end
            end
            COLLECT: begin
                if (ready != '0) begin
                    mask_d   = ready;
                    tvalid_d = 1'b1;
                    state_d  = OFFER;
                end else if (active == '0) begin
                    all_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            OFFER: begin
                if (tvalid_q && fetch_s_tready) begin
                    tvalid_d = 1'b0;
                    outst_d  = mask_q;
                    tmo_d    = '0;
                    state_d  = ROUND;
                end
            end
            ROUND: begin
                if (beat) begin
                    outst_left = outst_q;
                    outst_left[fetch_beat_id] = 1'b0;
                    outst_d = outst_left;
                    tmo_d   = '0;
                    if (!outst_q[fetch_beat_id]) err_d[KIANA_SCHED_ERR_BAD_BEAT] = 1'b1;
                    // Both a short last beat and an early drain end the round with an error.
                    if (fetch_beat_last || (outst_left == '0)) begin
                        state_d = COLLECT;
                        if (fetch_beat_last != (outst_left == '0))
                            err_d[KIANA_SCHED_ERR_LAST_MISMATCH] = 1'b1;
                    end
                end else if (tmo_q >= CNT_W'(ROUND_TIMEOUT - 1)) begin
                    err_d[KIANA_SCHED_ERR_TIMEOUT] = 1'b1;
                    state_d = COLLECT;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; always_comb uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            outst_q    <= '0;
            tmo_q      <= '0;
            tvalid_q   <= 1'b0;
            all_done_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            outst_q    <= outst_d;
            tmo_q      <= tmo_d;
            tvalid_q   <= tvalid_d;
            all_done_q <= all_done_d;
            err_q      <= err_d;
        end
    end

    assign fetch_s_tvalid  = tvalid_q;
    assign fetch_warp_mask = mask_q;
    assign busy            = (state_q != IDLE);
    assign all_done        = all_done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_warp_sched_ctrl.sv
// Directed bench for warp_sched_ctrl: hand-computed expectations for offers,
// slot-state priority, barrier release, completion, protocol errors and reset.
module tb_warp_sched_ctrl;
    import warp_sched_ctrl_pkg::*;

    localparam int NW  = 32;
    localparam int WW  = 5;
    localparam int TMO = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] launch_mask;
    logic          fetch_s_tvalid;
    logic          fetch_s_tready;
    logic [NW-1:0] fetch_warp_mask;
    logic          fetch_beat_valid, fetch_beat_last;
    logic [WW-1:0] fetch_beat_id;
    logic          issue_done_valid, stall_set_valid, stall_clr_valid, bar_valid, exit_valid;
    logic [WW-1:0] issue_done_id, stall_set_id, stall_clr_id, bar_id, exit_id;
    logic          busy, all_done;
    logic [3:0]    err;

    int n_checks = 0;
    int n_errors = 0;

    warp_sched_ctrl #(.NUM_WARPS(NW), .WID_W(WW), .ROUND_TIMEOUT(TMO)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .launch_mask      (launch_mask),
        .fetch_s_tvalid   (fetch_s_tvalid),
        .fetch_s_tready   (fetch_s_tready),
        .fetch_warp_mask  (fetch_warp_mask),
        .fetch_beat_valid (fetch_beat_valid),
        .fetch_beat_last  (fetch_beat_last),
        .fetch_beat_id    (fetch_beat_id),
        .issue_done_valid (issue_done_valid),
        .issue_done_id    (issue_done_id),
        .stall_set_valid  (stall_set_valid),
        .stall_set_id     (stall_set_id),
        .stall_clr_valid  (stall_clr_valid),
        .stall_clr_id     (stall_clr_id),
        .bar_valid        (bar_valid),
        .bar_id           (bar_id),
        .exit_valid       (exit_valid),
        .exit_id          (exit_id),
        .busy             (busy),
        .all_done         (all_done),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; launch_mask = '0; fetch_s_tready = 0;
        fetch_beat_valid = 0; fetch_beat_last = 0; fetch_beat_id = '0;
        issue_done_valid = 0; stall_set_valid = 0; stall_clr_valid = 0;
        bar_valid = 0; exit_valid = 0;
        issue_done_id = '0; stall_set_id = '0; stall_clr_id = '0; bar_id = '0; exit_id = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    task automatic launch(input logic [NW-1:0] m);
        start = 1; launch_mask = m;
        tick();
        start = 0; launch_mask = '0;
    endtask

    task automatic wait_offer(input string tag, input logic [NW-1:0] exp);
        int n = 0;
        while (!fetch_s_tvalid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(fetch_s_tvalid), 32'd1);
        check({tag, "_mask"}, fetch_warp_mask, exp);
    endtask

    task automatic accept();
        fetch_s_tready = 1;
        tick();
        fetch_s_tready = 0;
    endtask

    task automatic beat(input logic [WW-1:0] id, input logic last);
        fetch_beat_valid = 1; fetch_beat_id = id; fetch_beat_last = last;
        tick();
        fetch_beat_valid = 0; fetch_beat_last = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_tvalid", 32'(fetch_s_tvalid), 0);
        check("rst_mask", fetch_warp_mask, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(all_done), 0);
        check("rst_err", 32'(err), 0);

        // Single round, mask 0x5, fetch accepts after 3 cycles
        launch(32'h5);
        check("t1_busy", 32'(busy), 1);
        wait_offer("t1_offer", 32'h5);
        tick(3);
        check("t1_hold_valid", 32'(fetch_s_tvalid), 1);
        check("t1_hold_mask", fetch_warp_mask, 32'h5);
        accept();
        check("t1_drop_valid", 32'(fetch_s_tvalid), 0);
        beat(5'd0, 1'b0);
        check("t1_err_b0", 32'(err), 0);
        beat(5'd2, 1'b1);
        check("t1_err_b2", 32'(err), 0);
        check("t1_pending", u_dut.u_slot.pending_q, 32'h5);
        check("t1_state", 32'(u_dut.state_q), 32'(COLLECT));
        // Retire slot 0 under a temporary stall so both slots free up together
        issue_done_valid = 1; issue_done_id = 5'd0; stall_set_valid = 1; stall_set_id = 5'd0;
        tick();
        stall_set_valid = 0;
        issue_done_id = 5'd2; stall_clr_valid = 1; stall_clr_id = 5'd0;
        tick();
        issue_done_valid = 0; stall_clr_valid = 0;
        check("t1_no_offer", 32'(fetch_s_tvalid), 0);
        wait_offer("t1_offer2", 32'h5);

        // Stall exclusion and stall_set-over-stall_clr priority
        do_reset();
        start = 1; launch_mask = 32'hF; stall_set_valid = 1; stall_set_id = 5'd1;
        tick();
        start = 0; launch_mask = '0; stall_set_valid = 0;
        check("t2_err_launch", 32'(err), 0);
        wait_offer("t2_offer", 32'hD);
        accept();
        beat(5'd0, 1'b0);
        beat(5'd2, 1'b0);
        beat(5'd3, 1'b1);
        check("t2_err", 32'(err), 0);
        stall_set_valid = 1; stall_set_id = 5'd1; stall_clr_valid = 1; stall_clr_id = 5'd1;
        tick();
        stall_set_valid = 0; stall_clr_valid = 0;
        tick(2);
        check("t2_still_stalled", 32'(fetch_s_tvalid), 0);
        stall_clr_valid = 1; stall_clr_id = 5'd1;
        tick();
        stall_clr_valid = 0;
        wait_offer("t2_offer2", 32'h2);

        // Barrier: both warps must arrive before the next offer
        do_reset();
        launch(32'h3);
        wait_offer("t3_offer", 32'h3);
        accept();
        beat(5'd0, 1'b0);
        beat(5'd1, 1'b1);
        issue_done_valid = 1; issue_done_id = 5'd0; bar_valid = 1; bar_id = 5'd0;
        tick();
        issue_done_valid = 0; bar_valid = 0;
        tick(2);
        check("t3_wait_one", 32'(fetch_s_tvalid), 0);
        issue_done_valid = 1; issue_done_id = 5'd1; bar_valid = 1; bar_id = 5'd1;
        tick();
        issue_done_valid = 0; bar_valid = 0;
        check("t3_bar_set", u_dut.u_slot.barrier_q, 32'h3);
        tick();
        check("t3_bar_clear", u_dut.u_slot.barrier_q, 32'h0);
        check("t3_no_offer_yet", 32'(fetch_s_tvalid), 0);
        wait_offer("t3_offer2", 32'h3);

        // Exit and completion
        do_reset();
        launch(32'h1);
        wait_offer("t4_offer", 32'h1);
        accept();
        beat(5'd0, 1'b1);
        exit_valid = 1; exit_id = 5'd0;
        tick();
        exit_valid = 0;
        check("t4_done_early", 32'(all_done), 0);
        check("t4_busy_early", 32'(busy), 1);
        tick();
        check("t4_done", 32'(all_done), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_state", 32'(u_dut.state_q), 32'(IDLE));
        tick();
        check("t4_done_pulse", 32'(all_done), 0);
        // Empty launch completes immediately; exit of an inactive slot flags err[1]
        launch(32'h0);
        check("t4_empty_done", 32'(all_done), 1);
        check("t4_empty_busy", 32'(busy), 0);
        exit_valid = 1; exit_id = 5'd5;
        tick();
        exit_valid = 0;
        check("t4_inactive_err", 32'(err), 32'h2);

        // Protocol error: beat for a slot not outstanding
        do_reset();
        launch(32'h1);
        wait_offer("t5_offer", 32'h1);
        accept();
        beat(5'd4, 1'b0);
        check("t5_bad_beat", 32'(err), 32'h1);
        check("t5_still_round", 32'(u_dut.state_q), 32'(ROUND));
        beat(5'd0, 1'b1);
        check("t5_good_last", 32'(err), 0);

        // Protocol error: last beat with a slot still outstanding, then early drain
        do_reset();
        launch(32'h3);
        wait_offer("t6_offer", 32'h3);
        accept();
        beat(5'd0, 1'b1);
        check("t6_short_last", 32'(err), 32'h4);
        check("t6_state", 32'(u_dut.state_q), 32'(COLLECT));
        wait_offer("t6_offer2", 32'h2);
        accept();
        beat(5'd1, 1'b0);
        check("t6_no_last", 32'(err), 32'h4);

        // Round timeout
        do_reset();
        launch(32'h1);
        wait_offer("t7_offer", 32'h1);
        accept();
        tick(TMO - 1);
        check("t7_before_tmo", 32'(err), 0);
        tick();
        check("t7_tmo", 32'(err), 32'h8);
        check("t7_state", 32'(u_dut.state_q), 32'(COLLECT));

        // Reset in the middle of a round
        do_reset();
        launch(32'h1);
        wait_offer("t8_offer", 32'h1);
        accept();
        rst_n = 0;
        #1;
        check("t8_rst_tvalid", 32'(fetch_s_tvalid), 0);
        check("t8_rst_mask", fetch_warp_mask, 0);
        check("t8_rst_busy", 32'(busy), 0);
        check("t8_rst_err", 32'(err), 0);
        fetch_beat_valid = 1; fetch_beat_id = 5'd0; fetch_beat_last = 1;
        tick(2);
        fetch_beat_valid = 0; fetch_beat_last = 0;
        rst_n = 1;
        tick();
        check("t8_pending", u_dut.u_slot.pending_q, 0);
        launch(32'h2);
        wait_offer("t8_offer2", 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
